// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, port IDs,
// memory-latency bounds and the saturating counter helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_L = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant picker; combinational, the last grant is held by
// the caller. req[0]/grant[0] is port C, req[1]/grant[1] is port L.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // One-hot grant: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    grant = 2'b00;
    if (!enable) begin
      grant = 2'b00;
    end else if (req == 2'b11) begin
      grant = (last_grant == PORT_L) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between CPU (C) and loader (L) requesters.
// Optional grant/conflict statistics are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       c_grant_cnt,
  output logic [15:0]       l_grant_cnt,
  output logic [15:0]       conflict_cnt
`endif
);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
    $error("dmem_arbiter: MEM_LAT out of range 1..4");
  end

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  arb_state_e        state_r;
  logic              last_grant_r;
  logic              owner_r;
  logic              owner_we_r;
  logic [2:0]        cnt_r;
  logic              m_en_r;
  logic              m_we_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wdata_r;
  logic              c_rvalid_r;
  logic              l_rvalid_r;
  logic [DATA_W-1:0] c_rdata_r;
  logic [DATA_W-1:0] l_rdata_r;

  logic              idle_s;
  logic [1:0]        grant_s;
  logic              accept_s;
  logic              sel_port_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [DATA_W-1:0] capture_s;

  // Ready is combinational and must read 0 while reset is held.
  assign idle_s = rst & (state_r == IDLE);

  rr_arb2 u_rr_arb2 (
    .req        ({l_valid, c_valid}),
    .last_grant (last_grant_r),
    .enable     (idle_s),
    .grant      (grant_s)
  );

  assign c_ready    = grant_s[0];
  assign l_ready    = grant_s[1];
  assign accept_s   = grant_s[0] | grant_s[1];
  assign sel_port_s = grant_s[1] ? PORT_L : PORT_C;
  assign capture_s  = owner_we_r ? {DATA_W{1'b0}} : m_rdata;

  // Payload of the granted requester.
  always_comb begin
    sel_we_s    = c_we;
    sel_addr_s  = c_addr;
    sel_wdata_s = c_wdata;
    if (grant_s[1]) begin
      sel_we_s    = l_we;
      sel_addr_s  = l_addr;
      sel_wdata_s = l_wdata;
    end else begin
      sel_we_s    = c_we;
      sel_addr_s  = c_addr;
      sel_wdata_s = c_wdata;
    end
  end

  // Transaction FSM: accept, single-cycle memory strobe, latency count, response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= PORT_L;
      owner_r      <= PORT_C;
      owner_we_r   <= 1'b0;
      cnt_r        <= 3'd0;
      m_en_r       <= 1'b0;
      m_we_r       <= 1'b0;
      m_addr_r     <= {ADDR_W{1'b0}};
      m_wdata_r    <= {DATA_W{1'b0}};
      c_rvalid_r   <= 1'b0;
      l_rvalid_r   <= 1'b0;
      c_rdata_r    <= {DATA_W{1'b0}};
      l_rdata_r    <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            owner_r      <= sel_port_s;
            owner_we_r   <= sel_we_s;
            last_grant_r <= sel_port_s;
            m_en_r       <= 1'b1;
            m_we_r       <= sel_we_s;
            m_addr_r     <= sel_addr_s;
            m_wdata_r    <= sel_wdata_s;
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          m_en_r  <= 1'b0;
          m_we_r  <= 1'b0;
          cnt_r   <= LAT_LOAD;
          state_r <= WAIT;
        end
        WAIT: begin
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            if (owner_r == PORT_C) begin
              c_rvalid_r <= 1'b1;
              c_rdata_r  <= capture_s;
            end else begin
              l_rvalid_r <= 1'b1;
              l_rdata_r  <= capture_s;
            end
            state_r <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        DONE: begin
          c_rvalid_r <= 1'b0;
          l_rvalid_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          m_en_r     <= 1'b0;
          m_we_r     <= 1'b0;
          c_rvalid_r <= 1'b0;
          l_rvalid_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign m_en     = m_en_r;
  assign m_we     = m_we_r;
  assign m_addr   = m_addr_r;
  assign m_wdata  = m_wdata_r;
  assign c_rvalid = c_rvalid_r;
  assign l_rvalid = l_rvalid_r;
  assign c_rdata  = c_rdata_r;
  assign l_rdata  = l_rdata_r;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] c_grant_cnt_r;
  logic [15:0] l_grant_cnt_r;
  logic [15:0] conflict_cnt_r;

  // Saturating accept and contention counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_grant_cnt_r  <= 16'd0;
      l_grant_cnt_r  <= 16'd0;
      conflict_cnt_r <= 16'd0;
    end else begin
      if (grant_s[0]) begin
        c_grant_cnt_r <= sat_inc16(c_grant_cnt_r);
      end else begin
        c_grant_cnt_r <= c_grant_cnt_r;
      end
      if (grant_s[1]) begin
        l_grant_cnt_r <= sat_inc16(l_grant_cnt_r);
      end else begin
        l_grant_cnt_r <= l_grant_cnt_r;
      end
      if ((state_r == IDLE) && c_valid && l_valid) begin
        conflict_cnt_r <= sat_inc16(conflict_cnt_r);
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

  assign c_grant_cnt  = c_grant_cnt_r;
  assign l_grant_cnt  = l_grant_cnt_r;
  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
